// File: rtl/riscv_pkg.sv
// Shared fetch front-end definitions: FSM state type, default width and the NOP
// word presented on the decode slot before anything has been fetched.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Fetch bus: instruction-memory request/response port plus the decode-facing slot.
interface fetch_redirect_ctrl_if #(
  parameter int XLEN = riscv_pkg::XLEN_DEFAULT
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            stall;

  // Handshakes: a request transfers on any edge with imem_req && imem_gnt, and
  // exactly one imem_rvalid follows at least one cycle later; imem_addr holds
  // while imem_req waits for imem_gnt. The decode slot transfers on any edge with
  // if_valid && !stall, and stall freezes if_valid/if_pc/if_instr.
  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_instr,
    input  imem_gnt, imem_rvalid, imem_rdata, stall
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_instr,
    output imem_gnt, imem_rvalid, imem_rdata, stall
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry pc/instr holding register for a response that arrives while the
// decode slot is still occupied. Clear wins over load.
module fetch_skid_buf
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] new_pc,
  input  logic [XLEN-1:0] new_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= XLEN'(NOP_INSTR);
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= new_pc;
      instr <= new_instr;
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Instruction-fetch sequencer: one outstanding imem request, registered decode
// slot with a one-entry skid, and branch redirect that drains in-flight responses.
module fetch_redirect_ctrl
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  br_en,
  input  logic [XLEN-1:0]       br_target,
  output logic                  flush,
  output fetch_state_t          state,
  output logic                  skid_valid,
  fetch_redirect_ctrl_if.master bus
);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_REQ   = REQ;
  localparam logic [2:0] S_WAIT  = WAIT;
  localparam logic [2:0] S_HOLD  = HOLD;
  localparam logic [2:0] S_DRAIN = DRAIN;

  logic [2:0]      state_q;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] pend_pc;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] skid_instr;
  logic            slot_free;
  logic            skid_load;
  logic            skid_clear;

  assign target        = {br_target[XLEN-1:2], 2'b00};
  assign flush         = br_en;
  assign state         = fetch_state_t'(state_q);
  assign slot_free     = !bus.if_valid || !bus.stall;
  assign bus.imem_req  = (state_q == S_REQ);
  assign bus.imem_addr = fetch_pc;

  // A response that finds the slot occupied parks in the skid until decode moves.
  assign skid_load  = !br_en && (state_q == S_WAIT) && bus.imem_rvalid && !slot_free;
  assign skid_clear = br_en || ((state_q == S_HOLD) && !bus.stall);

  fetch_skid_buf #(.XLEN(XLEN)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_load),
    .clear     (skid_clear),
    .new_pc    (req_pc),
    .new_instr (bus.imem_rdata),
    .valid     (skid_valid),
    .pc        (skid_pc),
    .instr     (skid_instr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      fetch_pc     <= RESET_PC;
      req_pc       <= RESET_PC;
      pend_pc      <= RESET_PC;
      bus.if_valid <= 1'b0;
      bus.if_pc    <= '0;
      bus.if_instr <= XLEN'(NOP_INSTR);
    end else if (br_en) begin
      // Redirect outranks stall; a still-owed response forces a pass through DRAIN.
      bus.if_valid <= 1'b0;
      case (state_q)
        S_REQ: begin
          if (bus.imem_gnt) begin
            pend_pc <= target;
            state_q <= S_DRAIN;
          end else begin
            fetch_pc <= target;
            state_q  <= S_REQ;
          end
        end
        S_WAIT, S_DRAIN: begin
          if (bus.imem_rvalid) begin
            fetch_pc <= target;
            state_q  <= S_REQ;
          end else begin
            pend_pc <= target;
            state_q <= S_DRAIN;
          end
        end
        default: begin
          fetch_pc <= target;
          state_q  <= S_REQ;
        end
      endcase
    end else begin
      if (bus.if_valid && !bus.stall) bus.if_valid <= 1'b0;
      case (state_q)
        S_IDLE: state_q <= S_REQ;
        S_REQ: begin
          if (bus.imem_gnt) begin
            req_pc  <= fetch_pc;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid && slot_free) begin
            bus.if_valid <= 1'b1;
            bus.if_pc    <= req_pc;
            bus.if_instr <= bus.imem_rdata;
            fetch_pc     <= req_pc + XLEN'(4);
            state_q      <= S_REQ;
          end else if (bus.imem_rvalid) begin
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!bus.stall) begin
            bus.if_valid <= 1'b1;
            bus.if_pc    <= skid_pc;
            bus.if_instr <= skid_instr;
            fetch_pc     <= skid_pc + XLEN'(4);
            state_q      <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (bus.imem_rvalid) begin
            fetch_pc <= pend_pc;
            state_q  <= S_REQ;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: memory responder, directed + random stimulus,
// and a scoreboard monitor fed by a sequential-PC reference model.
module tb_fetch_redirect_ctrl;
  import riscv_pkg::*;

  localparam int              XLEN     = 32;
  localparam int              W        = 2 * XLEN;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            br_en = 1'b0;
  logic [XLEN-1:0] br_target = '0;
  logic            flush;
  logic            skid_valid;
  fetch_state_t    state;

  fetch_redirect_ctrl_if #(.XLEN(XLEN)) bus ();

  fetch_redirect_ctrl #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .br_en      (br_en),
    .br_target  (br_target),
    .flush      (flush),
    .state      (state),
    .skid_valid (skid_valid),
    .bus        (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0]    exp_q[$];
  logic [XLEN-1:0] exp_tail;
  logic [XLEN-1:0] req_exp;
  int n_cmp = 0;
  int n_err = 0;
  int n_consumed = 0;

  int gnt_pct = 100;
  int lat_min = 1;
  int lat_max = 1;

  function automatic logic [XLEN-1:0] mem_word(input logic [XLEN-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back({exp_tail, mem_word(exp_tail)});
      exp_tail += 32'd4;
    end
  endtask

  // The consumed instruction stream and the granted address stream both run
  // sequentially from the reset PC or from the newest redirect target.
  task automatic restart(input logic [XLEN-1:0] pc);
    exp_q.delete();
    exp_tail = pc;
    req_exp  = pc;
    refill();
  endtask

  task automatic wait_state(input fetch_state_t s, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (state !== s && n < budget);
    if (state !== s) check("wait_state", XLEN'(state), XLEN'(s));
  endtask

  // ---------------- memory responder ----------------
  initial begin : mem_model
    logic            pend;
    int              cnt;
    logic [XLEN-1:0] paddr;
    pend = 1'b0;
    cnt = 0;
    paddr = '0;
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.imem_rvalid = 1'b0;
      bus.imem_gnt = 1'b0;
      bus.imem_rdata = $urandom;
      if (!rst_n) begin
        pend = 1'b0;
        continue;
      end
      if (pend) begin
        if (cnt == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata = mem_word(paddr);
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (bus.imem_req && !pend && int'($urandom_range(1, 100)) <= gnt_pct) begin
        bus.imem_gnt = 1'b1;
        pend = 1'b1;
        paddr = bus.imem_addr;
        cnt = int'($urandom_range(lat_min, lat_max)) - 1;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [W-1:0] e;
    restart(RESET_PC);
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        restart(RESET_PC);
        continue;
      end
      check("flush", XLEN'(flush), XLEN'(br_en));
      if (bus.imem_req && bus.imem_gnt) check("req_addr", bus.imem_addr, req_exp);
      if (bus.if_valid && !bus.stall && !br_en) begin
        e = exp_q.pop_front();
        n_consumed++;
        check("if_pc", bus.if_pc, e[W-1:XLEN]);
        check("if_instr", bus.if_instr, e[XLEN-1:0]);
      end
      if (br_en) restart({br_target[XLEN-1:2], 2'b00});
      else if (bus.imem_req && bus.imem_gnt) req_exp += 32'd4;
      refill();
    end
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [XLEN-1:0] snap_pc;
    int n;
    bus.stall = 1'b0;
    rst_n = 1'b0;
    br_en = 1'b0;
    br_target = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_imem_req", XLEN'(bus.imem_req), 32'd0);
    check("rst_imem_addr", bus.imem_addr, RESET_PC);
    check("rst_if_valid", XLEN'(bus.if_valid), 32'd0);
    check("rst_if_pc", bus.if_pc, 32'd0);
    check("rst_if_instr", bus.if_instr, 32'h0000_0013);
    check("rst_state", XLEN'(state), XLEN'(IDLE));

    // Linear fetch: one instruction every two cycles
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_req", XLEN'(bus.imem_req), 32'd1);
    check("first_addr", bus.imem_addr, RESET_PC);
    repeat (7) @(posedge clk);
    #1;
    check("lin_gap_valid", XLEN'(bus.if_valid), 32'd0);
    @(posedge clk); #1;
    check("lin_valid", XLEN'(bus.if_valid), 32'd1);
    check("lin_pc", bus.if_pc, 32'd12);
    check("lin_instr", bus.if_instr, mem_word(32'd12));

    // Stall into skid
    @(negedge clk);
    bus.stall = 1'b1;
    snap_pc = bus.if_pc;
    wait_state(HOLD, 20);
    check("hold_if_pc", bus.if_pc, snap_pc);
    check("hold_if_valid", XLEN'(bus.if_valid), 32'd1);
    check("hold_skid", XLEN'(skid_valid), 32'd1);
    bus.stall = 1'b0;
    @(posedge clk); #1;
    check("unskid_pc", bus.if_pc, snap_pc + 32'd4);
    check("unskid_instr", bus.if_instr, mem_word(snap_pc + 32'd4));
    check("unskid_addr", bus.imem_addr, snap_pc + 32'd8);
    lat_min = 3;
    lat_max = 3;

    // Redirect during WAIT
    wait_state(WAIT, 20);
    br_en = 1'b1;
    br_target = 32'h100;
    #1;
    check("wait_flush", XLEN'(flush), 32'd1);
    @(posedge clk); #1;
    check("wait_br_valid", XLEN'(bus.if_valid), 32'd0);
    check("wait_br_state", XLEN'(state), XLEN'(DRAIN));
    @(negedge clk);
    br_en = 1'b0;
    wait_state(REQ, 20);
    check("wait_br_addr", bus.imem_addr, 32'h100);

    // Double redirect while draining
    wait_state(WAIT, 20);
    br_en = 1'b1;
    br_target = 32'h200;
    @(negedge clk);
    check("dbl_state", XLEN'(state), XLEN'(DRAIN));
    br_target = 32'h300;
    @(negedge clk);
    br_en = 1'b0;
    wait_state(REQ, 20);
    check("dbl_addr", bus.imem_addr, 32'h300);

    // Redirect with stall in HOLD, unaligned target
    bus.stall = 1'b1;
    wait_state(HOLD, 40);
    br_en = 1'b1;
    br_target = 32'h103;
    @(posedge clk); #1;
    check("hold_br_valid", XLEN'(bus.if_valid), 32'd0);
    check("hold_br_skid", XLEN'(skid_valid), 32'd0);
    check("hold_br_state", XLEN'(state), XLEN'(REQ));
    check("hold_br_addr", bus.imem_addr, 32'h100);

    // Wrap at the top of the address space
    @(negedge clk);
    bus.stall = 1'b0;
    br_target = 32'hFFFF_FFFC;
    @(negedge clk);
    br_en = 1'b0;
    n = 0;
    while (!(bus.imem_req && bus.imem_addr == 32'hFFFF_FFFC) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("wrap_top_addr", bus.imem_addr, 32'hFFFF_FFFC);
    wait_state(WAIT, 20);
    wait_state(REQ, 20);
    check("wrap_next_addr", bus.imem_addr, 32'h0);

    // Asynchronous reset mid-WAIT
    wait_state(WAIT, 20);
    #2 rst_n = 1'b0;
    #1;
    check("arst_imem_req", XLEN'(bus.imem_req), 32'd0);
    check("arst_imem_addr", bus.imem_addr, RESET_PC);
    check("arst_if_valid", XLEN'(bus.if_valid), 32'd0);
    check("arst_if_pc", bus.if_pc, 32'd0);
    check("arst_if_instr", bus.if_instr, 32'h0000_0013);
    check("arst_state", XLEN'(state), XLEN'(IDLE));
    check("arst_skid", XLEN'(skid_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rerst_req", XLEN'(bus.imem_req), 32'd1);
    check("rerst_addr", bus.imem_addr, RESET_PC);

    // Random traffic
    gnt_pct = 70;
    lat_min = 1;
    lat_max = 4;
    n_consumed = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.stall = ($urandom_range(0, 99) < 30);
      br_en = ($urandom_range(0, 99) < 4);
      br_target = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4095));
    end
    @(negedge clk);
    bus.stall = 1'b0;
    br_en = 1'b0;
    repeat (20) @(negedge clk);
    check("random_progress", XLEN'(n_consumed > 50), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Instruction-fetch sequencer between the instruction memory port and the decode stage. Owns the fetch PC and issues one outstanding request at a time to instruction memory. Presents fetched instructions to decode with a valid/stall handshake and a one-entry skid buffer. Consumes the branch/jump redirect (`br_en`, target) from branch control in EX: it flushes younger work, discards in-flight responses and restarts fetch at the target.

## Interface
- `XLEN`, 32: address/data width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `br_en`  in  1  redirect request from branch control (taken branch or jump).
- `br_target`  in  XLEN  redirect address; bits [1:0] ignored (forced 00).
- `stall`  in  1  decode cannot accept; holds `if_*` outputs.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  XLEN  fetch address, word aligned.
- `imem_gnt`  in  1  request accepted this cycle (meaningful only with `imem_req`).
- `imem_rvalid`  in  1  response valid (exactly one per granted request, ≥1 cycle after gnt).
- `imem_rdata`  in  XLEN  instruction word.
- `if_valid`  out  1  `if_instr`/`if_pc` valid to decode.
- `if_pc`  out  XLEN  PC of presented instruction.
- `if_instr`  out  XLEN  presented instruction.
- `flush`  out  1  kill IF/ID and ID/EX; combinational copy of `br_en`.

## Operation
- **Reset values:** state IDLE, `imem_req` 0, `imem_addr` RESET_PC, `if_valid` 0, `if_pc` 0, `if_instr` 32'h0000_0013 (NOP), skid empty.
- **Output-slot handshake:** decode consumes `if_*` on any edge with `if_valid`=1 and `stall`=0. The slot is free when `!if_valid || !stall`.
- **States:**
  - IDLE: first edge after reset release → REQ.
  - REQ: `imem_req`=1. `imem_addr`=fetch_pc stays stable until `imem_gnt`. On gnt → WAIT; the request PC is latched.
  - WAIT: on `imem_rvalid`:
    - slot free: load `if_*` from rdata/request PC, `if_valid`←1, fetch_pc←request PC+4, → REQ.
    - slot occupied: load skid buffer, → HOLD.
  - HOLD: when `stall`=0, skid moves to `if_*` (the old entry is consumed), fetch_pc←skid PC+4, → REQ.
  - DRAIN: a discarded response is outstanding. On `imem_rvalid`, drop the data and go → REQ with fetch_pc = pending target.
- **Redirect (`br_en`=1)** has priority over `stall` and over all other transitions. In every state: `flush`=1 the same cycle, `if_valid`←0 and skid cleared at the next edge.
  - IDLE/REQ without gnt/HOLD: fetch_pc←target, → REQ. In REQ the address change is permitted only here.
  - REQ with gnt same cycle, or WAIT without rvalid: pending←target, → DRAIN.
  - WAIT with rvalid same cycle: drop data, fetch_pc←target, → REQ.
  - DRAIN without rvalid: pending←target, overwritten by the newest redirect. DRAIN with rvalid: drop data, → REQ with the new target.
- **Arithmetic:** PC+4 is modulo 2^XLEN, so 32'hFFFF_FFFC+4 = 0.
- **Reset mid-transaction:** all state cleared immediately. The memory side must also be reset, because no stale rvalid is tolerated.

## Timing
- `flush` is combinational from `br_en` (zero latency). All other outputs are registered; `imem_req` decodes directly from the state register.
- **Best-case throughput:** 1 instruction per 2 cycles. REQ+gnt at t, rvalid at t+1, `if_valid` and next REQ at t+2.
- **Redirect latency:** `br_en` at t in REQ/HOLD gives `imem_addr`=target at t+1. From DRAIN it is issued at the cycle after the discarded rvalid.
- **Reset release:** `imem_req` first asserts one cycle after `rst_n` rises, at RESET_PC.

## Structure
- **Shared package `riscv_pkg`:** `fetch_state_t` enum (IDLE, REQ, WAIT, HOLD, DRAIN), `NOP_INSTR` = 32'h0000_0013, `XLEN` default.
- **Sub-module `fetch_skid_buf`:** one-entry pc+instr register with load/clear/valid. Everything else (FSM, fetch_pc, pending target, output register) lives in the top.

## Test plan
- **Reset and linear fetch:** reset, gnt=1, rvalid one cycle after gnt, stall=0 → addresses 0,4,8,12. `if_pc` follows with `if_valid` every 2nd cycle; `if_instr` matches rdata.
- **Stall into skid:** hold `stall`=1 while `if_valid`=1 and the next rvalid returns rdata=X at pc 8 → state HOLD, `if_*` unchanged. Release stall → `if_pc`=8, `if_instr`=X next edge, next `imem_addr`=12.
- **Redirect during WAIT:** `br_en` with target 32'h100 before rvalid → `flush`=1 that cycle, `if_valid`=0 next edge. The late rvalid data never appears on `if_*`; next `imem_addr`=32'h100.
- **Double redirect:** targets 0x200 then 0x300 while in DRAIN → only 0x300 is fetched; no request to 0x200.
- **Redirect vs. stall:** `br_en`=1 and `stall`=1 together in HOLD → skid dropped, `if_valid`=0, `imem_addr`=target. Also, `br_target`=0x103 → `imem_addr`=0x100.
- **Wrap and async reset:** fetch at 32'hFFFF_FFFC → next `imem_addr`=0. Asserting `rst_n` low mid-WAIT → outputs go to reset values without a clock edge.
